// File: rtl/seq_multiplier_if.sv
// Start/busy/done handshake between the ALU controller (master) and the
// sequential multiplier (slave).
interface seq_multiplier_if #(
    parameter int unsigned WIDTH = 4
) ();
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per clock on operand
// magnitudes, sign applied to the accumulated result on the last step.
module seq_multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    seq_multiplier_if.slave bus
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]       r_state,   w_state_nxt;
    logic [WIDTH-1:0] r_mcand,   w_mcand_nxt;
    logic [WIDTH-1:0] r_mplier,  w_mplier_nxt;
    logic             r_neg,     w_neg_nxt;
    logic [PW-1:0]    r_acc,     w_acc_nxt;
    logic [PW-1:0]    r_product, w_product_nxt;
    logic [CW-1:0]    r_count,   w_count_nxt;
    logic             r_busy;
    logic             r_done;
    logic [PW-1:0]    w_sum;
    logic             w_last;

    assign w_sum  = r_acc + (r_mplier[0] ? (PW'(r_mcand) << r_count) : PW'(0));
    assign w_last = (r_count == CW'(WIDTH - 1));

    // Next-state and datapath update; FIN accepts a new start exactly like IDLE.
    always_comb begin
        w_state_nxt   = r_state;
        w_mcand_nxt   = r_mcand;
        w_mplier_nxt  = r_mplier;
        w_neg_nxt     = r_neg;
        w_acc_nxt     = r_acc;
        w_product_nxt = r_product;
        w_count_nxt   = r_count;
        case (r_state)
            S_RUN: begin
                w_acc_nxt    = w_sum;
                w_mplier_nxt = r_mplier >> 1;
                w_count_nxt  = r_count + CW'(1);
                if (w_last) begin
                    w_state_nxt   = S_FIN;
                    w_product_nxt = r_neg ? (~w_sum + PW'(1)) : w_sum;
                end
            end
            S_IDLE, S_FIN: begin
                w_state_nxt = S_IDLE;
                if (bus.start) begin
                    w_state_nxt  = S_RUN;
                    w_mcand_nxt  = (bus.signed_mode && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
                    w_mplier_nxt = (bus.signed_mode && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;
                    w_neg_nxt    = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    w_acc_nxt    = '0;
                    w_count_nxt  = '0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_neg     <= 1'b0;
            r_acc     <= '0;
            r_product <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mcand   <= w_mcand_nxt;
            r_mplier  <= w_mplier_nxt;
            r_neg     <= w_neg_nxt;
            r_acc     <= w_acc_nxt;
            r_product <= w_product_nxt;
            r_count   <= w_count_nxt;
            r_busy    <= (w_state_nxt == S_RUN);
            r_done    <= (w_state_nxt == S_FIN);
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.product = r_product;
endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench: a WIDTH=4 instance for directed and random cases and a
// WIDTH=8 instance for a random sweep, both checked against integer products.
module tb_seq_multiplier;
    typedef struct {
        int          exp_edge;
        logic [15:0] prod;
    } sb_t;

    logic clk;
    logic rst4;
    logic rst8;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    seq_multiplier_if #(.WIDTH(4)) if4 ();
    seq_multiplier_if #(.WIDTH(8)) if8 ();

    seq_multiplier #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst4), .bus(if4));
    seq_multiplier #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst8), .bus(if8));

    sb_t         q4[$];
    sb_t         q8[$];
    int          last_n4 = -100;
    int          last_n8 = -100;
    int          free4   = 0;
    int          free8   = 0;
    logic [15:0] held4   = '0;
    logic [15:0] held8   = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Exact product of the operands as integers, wrapped to 2*w bits.
    function automatic logic [15:0] ref_mul(input int w, input int unsigned a,
                                            input int unsigned b, input bit sm);
        longint av = longint'(a);
        longint bv = longint'(b);
        longint m  = (longint'(1) << (2 * w)) - 1;
        if (sm && a[w-1]) av = av - (longint'(1) << w);
        if (sm && b[w-1]) bv = bv - (longint'(1) << w);
        return 16'((av * bv) & m);
    endfunction

    // Called at a negedge; waits until the model says the DUT can accept.
    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input bit sm);
        while (cyc + 1 < free4) @(negedge clk);
        if4.a = a; if4.b = b; if4.signed_mode = sm; if4.start = 1'b1;
        last_n4 = cyc + 1;
        free4   = last_n4 + 5;
        q4.push_back('{exp_edge: last_n4 + 4, prod: ref_mul(4, a, b, sm)});
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input bit sm);
        while (cyc + 1 < free8) @(negedge clk);
        if8.a = a; if8.b = b; if8.signed_mode = sm; if8.start = 1'b1;
        last_n8 = cyc + 1;
        free8   = last_n8 + 9;
        q8.push_back('{exp_edge: last_n8 + 8, prod: ref_mul(8, a, b, sm)});
    endtask

    task automatic release4();
        @(negedge clk);
        if4.start = 1'b0;
    endtask

    task automatic release8();
        @(negedge clk);
        if8.start = 1'b0;
    endtask

    initial begin : mon4
        sb_t e;
        bit  exp_done;
        forever begin
            @(posedge clk);
            #1;
            if (rst4) begin
                chk("rst4_busy", 16'(if4.busy), 16'd0);
                chk("rst4_done", 16'(if4.done), 16'd0);
                chk("rst4_product", 16'(if4.product), 16'd0);
            end else begin
                exp_done = (q4.size() > 0) && (q4[0].exp_edge == cyc);
                chk("busy4", 16'(if4.busy), 16'(cyc >= last_n4 && cyc < last_n4 + 4));
                chk("done4", 16'(if4.done), 16'(exp_done));
                if (exp_done) begin
                    e     = q4.pop_front();
                    held4 = e.prod;
                end
                chk("product4", 16'(if4.product), held4);
            end
        end
    end

    initial begin : mon8
        sb_t e;
        bit  exp_done;
        forever begin
            @(posedge clk);
            #1;
            if (rst8) begin
                chk("rst8_done", 16'(if8.done), 16'd0);
                chk("rst8_product", 16'(if8.product), 16'd0);
            end else begin
                exp_done = (q8.size() > 0) && (q8[0].exp_edge == cyc);
                chk("busy8", 16'(if8.busy), 16'(cyc >= last_n8 && cyc < last_n8 + 8));
                chk("done8", 16'(if8.done), 16'(exp_done));
                if (exp_done) begin
                    e     = q8.pop_front();
                    held8 = e.prod;
                end
                chk("product8", 16'(if8.product), held8);
            end
        end
    end

    initial begin : stim
        n_cmp = 0;
        n_bad = 0;
        rst4 = 1'b1; rst8 = 1'b1;
        if4.start = 1'b0; if4.signed_mode = 1'b0; if4.a = '0; if4.b = '0;
        if8.start = 1'b0; if8.signed_mode = 1'b0; if8.a = '0; if8.b = '0;
        repeat (2) @(negedge clk);
        rst4 = 1'b0; rst8 = 1'b0;
        repeat (2) @(negedge clk);

        fork
            begin : drive4
                issue4(4'd15, 4'd15, 1'b0); release4();
                repeat (3) @(negedge clk);
                issue4(4'b1000, 4'b0111, 1'b1); release4();
                issue4(4'b1000, 4'b1000, 1'b1); release4();
                issue4(4'd0, 4'd9, 1'b1); release4();
                // start held high across FIN with operands changed there
                issue4(4'd3, 4'd5, 1'b0);
                issue4(4'd2, 4'd6, 1'b0);
                release4();
                // start with new operands during RUN is ignored
                issue4(4'd7, 4'd9, 1'b0); release4();
                @(negedge clk);
                if4.start = 1'b1; if4.a = 4'd1; if4.b = 4'd1; if4.signed_mode = 1'b1;
                @(negedge clk);
                if4.start = 1'b0;
                // reset in the second RUN cycle aborts the operation
                issue4(4'd13, 4'd11, 1'b0); release4();
                @(negedge clk);
                rst4 = 1'b1;
                q4.delete(); held4 = '0; last_n4 = -100; free4 = 0;
                @(negedge clk);
                rst4 = 1'b0;
                repeat (8) @(negedge clk);
                for (int i = 0; i < 300; i++) begin
                    int g;
                    issue4(4'($urandom), 4'($urandom), 1'($urandom));
                    g = int'($urandom_range(0, 3));
                    if (g > 0) begin
                        release4();
                        repeat (g - 1) @(negedge clk);
                    end
                end
                release4();
            end
            begin : drive8
                for (int i = 0; i < 2000; i++) begin
                    int g;
                    issue8(8'($urandom), 8'($urandom), 1'($urandom));
                    g = int'($urandom_range(0, 3));
                    if (g > 0) begin
                        release8();
                        repeat (g - 1) @(negedge clk);
                    end
                end
                issue8(8'h80, 8'h80, 1'b1);
                issue8(8'hFF, 8'hFF, 1'b0);
                issue8(8'hFF, 8'h01, 1'b1);
                release8();
            end
        join

        repeat (20) @(negedge clk);
        chk("q4_drained", 16'(q4.size()), 16'd0);
        chk("q8_drained", 16'(q8.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
